// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC stage: next-PC mux select encodings used by
// pc_sequencer and by the downstream 4-to-1 next-PC multiplexer decode.
package pc_seq_pkg;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t SEL_SEQ = 2'b00;
  localparam pc_sel_t SEL_BR  = 2'b01;
  localparam pc_sel_t SEL_JMP = 2'b10;
  localparam pc_sel_t SEL_RET = 2'b11;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address stack. A push into a full stack overwrites
// the oldest entry and occupancy saturates at DEPTH; pop on empty is never issued.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr is the next write slot; the most recent entry sits just below it.
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_empty   = (r_cnt == '0);

  // NOTE: non-blocking assignments for every sequential register so all
  // flops update together from the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!o_full) r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // NOTE: storage has no reset; occupancy going to zero makes old contents
  // unreachable, and leaving the array unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_ptr] <= i_data;
  end

endmodule : ras_stack

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, next-PC candidate selection and optional
// return-address stack (compiled in when macro RAS_EN is defined).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                   PC_WIDTH     = 16,
  parameter int                   OFFSET_WIDTH = 8,
  parameter int                   RAS_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  input  logic                    jump,
  input  logic [PC_WIDTH-1:0]     jump_target,
  input  logic                    call,
  input  logic                    ret,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [1:0]              pc_sel,
  output logic [PC_WIDTH-1:0]     next_pc,
  output logic                    ras_overflow,
  output logic                    ras_underflow
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_seq;
  logic [PC_WIDTH-1:0] w_br;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic                w_ret_hit;

  assign w_seq = r_pc + PC_WIDTH'(1);
  assign w_br  = r_pc + PC_WIDTH'(signed'(branch_offset));

`ifdef RAS_EN
  logic w_ras_full;
  logic w_ras_empty;
  logic w_push;
  logic w_pop;
  logic r_ras_overflow;
  logic r_ras_underflow;

  // A ret against an empty stack falls through to the lower-priority requests.
  assign w_ret_hit = ret && !w_ras_empty;
  assign w_pop     = w_ret_hit && !stall;
  assign w_push    = call && !w_ret_hit && !stall;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_seq),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ras_overflow  <= 1'b0;
      r_ras_underflow <= 1'b0;
    end else if (!stall) begin
      if (w_push && w_ras_full)  r_ras_overflow  <= 1'b1;
      if (ret && w_ras_empty)    r_ras_underflow <= 1'b1;
    end
  end

  assign ras_overflow  = r_ras_overflow;
  assign ras_underflow = r_ras_underflow;
`else
  logic w_unused_ret;

  assign w_unused_ret  = ret;
  assign w_ret_hit     = 1'b0;
  assign w_ras_top     = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  // NOTE: both outputs get a default before the priority chain so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    pc_sel  = SEL_SEQ;
    next_pc = w_seq;
    if (w_ret_hit) begin
      pc_sel  = SEL_RET;
      next_pc = w_ras_top;
    end else if (call || jump) begin
      pc_sel  = SEL_JMP;
      next_pc = jump_target;
    end else if (branch_taken) begin
      pc_sel  = SEL_BR;
      next_pc = w_br;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_pc <= RESET_VECTOR;
    else if (!stall) r_pc <= next_pc;
  end

  assign pc = r_pc;

endmodule : pc_sequencer
